// File: rtl/amadeus_mem_bridge.sv
// -----------------------------------------------------------------------------
// amadeus_mem_bridge
//   Bridges the accelerator's single-beat memory strobes onto an external memory
//   port with a valid/ready request channel and a variable-latency, in-order
//   read-response channel. Requests are buffered in an in-order FIFO, the number
//   of issued-but-unanswered reads is bounded, and read data is returned to the
//   accelerator as a registered one-cycle pulse.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous reset, active-high
//   acc_addr       in   accelerator request address
//   acc_wdata      in   accelerator write data
//   acc_read       in   read request strobe
//   acc_write      in   write request strobe
//   acc_stall      out  FIFO full, requests this cycle are dropped
//   acc_rdata      out  returned read data (held until the next response)
//   acc_rvalid     out  one-cycle pulse per returned read
//   dram_req_valid out  request present on dram_req_*
//   dram_req_ready in   memory accepts request
//   dram_req_we    out  1 = write, 0 = read
//   dram_req_addr  out  request address
//   dram_req_wdata out  request write data
//   dram_rsp_valid in   read response beat
//   dram_rsp_data  in   read response data
//   busy           out  requests queued or reads outstanding
//   err_overflow   out  sticky: a request was dropped
//   err_unexp_rsp  out  sticky: response arrived with no read outstanding
// -----------------------------------------------------------------------------
module amadeus_mem_bridge #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 128,
   parameter int REQ_DEPTH       = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [DATA_W-1:0] acc_wdata,
   input  logic              acc_read,
   input  logic              acc_write,
   output logic              acc_stall,
   output logic [DATA_W-1:0] acc_rdata,
   output logic              acc_rvalid,
   output logic              dram_req_valid,
   input  logic              dram_req_ready,
   output logic              dram_req_we,
   output logic [ADDR_W-1:0] dram_req_addr,
   output logic [DATA_W-1:0] dram_req_wdata,
   input  logic              dram_rsp_valid,
   input  logic [DATA_W-1:0] dram_rsp_data,
   output logic              busy,
   output logic              err_overflow,
   output logic              err_unexp_rsp
);

   localparam int PW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {IDLE, ACTIVE} state_e;

   // FIFO storage: payload only, never reset
   logic              fifo_we_q    [REQ_DEPTH];
   logic [ADDR_W-1:0] fifo_addr_q  [REQ_DEPTH];
   logic [DATA_W-1:0] fifo_wdata_q [REQ_DEPTH];

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [OW-1:0]     outst_q, outst_d;
   state_e            state_q, state_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ovf_q, ovf_d;
   logic              unexp_q, unexp_d;

   logic fifo_empty;
   logic fifo_full;
   logic head_we;
   logic one_strobe;
   logic push;
   logic pop;
   logic issue_rd;
   logic rsp_ok;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(REQ_DEPTH));
   assign head_we    = fifo_we_q[rd_ptr_q];
   assign one_strobe = acc_read ^ acc_write;
   assign push       = one_strobe && !fifo_full;
   // A write at the head never waits on the read budget; a read does, and
   // since issue is strictly in order it also holds back everything behind it.
   assign dram_req_valid = !fifo_empty && (head_we || (outst_q < OW'(MAX_OUTSTANDING)));
   assign pop        = dram_req_valid && dram_req_ready;
   assign issue_rd   = pop && !head_we;
   assign rsp_ok     = dram_rsp_valid && (outst_q != '0);

   // Payload is forced to zero while the FIFO is empty so the port is clean after reset
   assign dram_req_we    = fifo_empty ? 1'b0 : head_we;
   assign dram_req_addr  = fifo_empty ? '0 : fifo_addr_q[rd_ptr_q];
   assign dram_req_wdata = fifo_empty ? '0 : fifo_wdata_q[rd_ptr_q];

   assign acc_stall     = fifo_full;
   assign acc_rdata     = rdata_q;
   assign acc_rvalid    = rvalid_q;
   assign err_overflow  = ovf_q;
   assign err_unexp_rsp = unexp_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      outst_d  = outst_q;
      rvalid_d = rsp_ok;
      rdata_d  = rdata_q;
      ovf_d    = ovf_q;
      unexp_d  = unexp_q;
      state_d  = state_q;
      busy     = (state_q == ACTIVE);

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);

      if (issue_rd && !rsp_ok)      outst_d = outst_q + OW'(1);
      else if (!issue_rd && rsp_ok) outst_d = outst_q - OW'(1);

      if (rsp_ok) rdata_d = dram_rsp_data;

      if ((acc_read && acc_write) || (one_strobe && fifo_full)) ovf_d = 1'b1;
      if (dram_rsp_valid && (outst_q == '0))                     unexp_d = 1'b1;

      // Registered state tracks whether anything is queued or in flight
      case (state_q)
         IDLE:    if ((count_d != '0) || (outst_d != '0)) state_d = ACTIVE;
         ACTIVE:  if ((count_d == '0) && (outst_d == '0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         outst_q  <= '0;
         state_q  <= IDLE;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         ovf_q    <= 1'b0;
         unexp_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         outst_q  <= outst_d;
         state_q  <= state_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         ovf_q    <= ovf_d;
         unexp_q  <= unexp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_we_q[wr_ptr_q]    <= acc_write;
         fifo_addr_q[wr_ptr_q]  <= acc_addr;
         fifo_wdata_q[wr_ptr_q] <= acc_wdata;
      end
   end

endmodule

// File: tb/tb_amadeus_mem_bridge.sv
module tb_amadeus_mem_bridge;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 128;
   localparam int DEPTH  = 4;
   localparam int MAXO   = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [ADDR_W-1:0] acc_addr = '0;
   logic [DATA_W-1:0] acc_wdata = '0;
   logic              acc_read = 1'b0;
   logic              acc_write = 1'b0;
   logic              acc_stall;
   logic [DATA_W-1:0] acc_rdata;
   logic              acc_rvalid;
   logic              dram_req_valid;
   logic              dram_req_ready = 1'b0;
   logic              dram_req_we;
   logic [ADDR_W-1:0] dram_req_addr;
   logic [DATA_W-1:0] dram_req_wdata;
   logic              dram_rsp_valid = 1'b0;
   logic [DATA_W-1:0] dram_rsp_data = '0;
   logic              busy;
   logic              err_overflow;
   logic              err_unexp_rsp;

   amadeus_mem_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REQ_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst(rst),
      .acc_addr(acc_addr), .acc_wdata(acc_wdata),
      .acc_read(acc_read), .acc_write(acc_write),
      .acc_stall(acc_stall), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
      .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
      .dram_req_we(dram_req_we), .dram_req_addr(dram_req_addr),
      .dram_req_wdata(dram_req_wdata),
      .dram_rsp_valid(dram_rsp_valid), .dram_rsp_data(dram_rsp_data),
      .busy(busy), .err_overflow(err_overflow), .err_unexp_rsp(err_unexp_rsp)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0b expected %0b", nm, $time, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge; returns 1ns later so
   // combinational outputs have settled and registered ones show the last edge.
   task automatic drive(input logic r, input logic rd, input logic wr, input logic rdy,
                        input logic rspv, input logic [31:0] a, input logic [127:0] wd,
                        input logic [127:0] rsp);
      @(negedge clk);
      rst = r; acc_read = rd; acc_write = wr; dram_req_ready = rdy;
      dram_rsp_valid = rspv; acc_addr = a; acc_wdata = wd; dram_rsp_data = rsp;
      #1;
   endtask

   typedef struct {
      logic rs, rd, wr, rdy, rspv, chk;
      logic stall, valid, busy, rv, ovf, unexp;
   } vec_t;

   typedef struct packed {
      logic          we;
      logic [31:0]   addr;
      logic [127:0]  wdata;
   } req_t;

   vec_t tbl[$];
   req_t mq[$];

   initial begin
      logic [127:0] d;
      int           outst_m;
      logic         exp_rv, exp_valid, full_m, ovf_m, rd, wr;
      logic [127:0] exp_rd;

      // rs rd wr rdy rspv chk | stall valid busy rv ovf unexp
      // Five reads with memory not ready, then stall and overflow
      tbl.push_back('{1,0,0,0,0,0, 0,0,0,0,0,0});
      tbl.push_back('{0,1,0,0,0,1, 0,0,0,0,0,0});
      tbl.push_back('{0,1,0,0,0,1, 0,1,1,0,0,0});
      tbl.push_back('{0,1,0,0,0,1, 0,1,1,0,0,0});
      tbl.push_back('{0,1,0,0,0,1, 0,1,1,0,0,0});
      tbl.push_back('{0,1,0,0,0,1, 1,1,1,0,0,0});
      tbl.push_back('{0,0,0,0,0,1, 1,1,1,0,1,0});
      // read&write together, then a response while idle
      tbl.push_back('{1,0,0,0,0,0, 0,0,0,0,0,0});
      tbl.push_back('{0,1,1,0,0,1, 0,0,0,0,0,0});
      tbl.push_back('{0,0,0,0,1,1, 0,0,0,0,1,0});
      tbl.push_back('{0,0,0,0,0,1, 0,0,0,0,1,1});
      // Six reads with ready high and no responses: four issue, the fifth waits
      tbl.push_back('{1,0,0,0,0,0, 0,0,0,0,0,0});
      tbl.push_back('{0,1,0,1,0,1, 0,0,0,0,0,0});
      tbl.push_back('{0,1,0,1,0,1, 0,1,1,0,0,0});
      tbl.push_back('{0,1,0,1,0,1, 0,1,1,0,0,0});
      tbl.push_back('{0,1,0,1,0,1, 0,1,1,0,0,0});
      tbl.push_back('{0,1,0,1,0,1, 0,1,1,0,0,0});
      tbl.push_back('{0,1,0,1,0,1, 0,0,1,0,0,0});
      tbl.push_back('{0,0,0,1,0,1, 0,0,1,0,0,0});
      tbl.push_back('{0,0,0,1,0,1, 0,0,1,0,0,0});
      tbl.push_back('{0,0,0,1,1,1, 0,0,1,0,0,0});
      tbl.push_back('{0,0,0,1,0,1, 0,1,1,1,0,0});
      tbl.push_back('{0,0,0,1,0,1, 0,0,1,0,0,0});

      foreach (tbl[i]) begin
         drive(tbl[i].rs, tbl[i].rd, tbl[i].wr, tbl[i].rdy, tbl[i].rspv,
               32'h100 + 32'(i), 128'(i), 128'hDEAD);
         if (tbl[i].chk) begin
            chk1($sformatf("row%0d stall", i), acc_stall, tbl[i].stall);
            chk1($sformatf("row%0d valid", i), dram_req_valid, tbl[i].valid);
            chk1($sformatf("row%0d busy", i), busy, tbl[i].busy);
            chk1($sformatf("row%0d rvalid", i), acc_rvalid, tbl[i].rv);
            chk1($sformatf("row%0d ovf", i), err_overflow, tbl[i].ovf);
            chk1($sformatf("row%0d unexp", i), err_unexp_rsp, tbl[i].unexp);
         end
      end

      // Single read, response five cycles after issue
      d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 1, 0, 32'h100, 0, 0);
      chk1("t1 valid enq cycle", dram_req_valid, 1'b0);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      chk1("t1 valid", dram_req_valid, 1'b1);
      chk1("t1 we", dram_req_we, 1'b0);
      chkw("t1 addr", 128'(dram_req_addr), 128'h100);
      repeat (4) drive(0, 0, 0, 1, 0, 0, 0, 0);
      chk1("t1 valid after issue", dram_req_valid, 1'b0);
      chk1("t1 busy outstanding", busy, 1'b1);
      drive(0, 0, 0, 1, 1, 0, 0, d);
      chk1("t1 rvalid early", acc_rvalid, 1'b0);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      chk1("t1 rvalid", acc_rvalid, 1'b1);
      chkw("t1 rdata", acc_rdata, d);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      chk1("t1 rvalid pulse", acc_rvalid, 1'b0);
      chkw("t1 rdata held", acc_rdata, d);
      chk1("t1 busy end", busy, 1'b0);

      // Write then read with ready toggling: order and payload stability
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 32'h200, 128'hAAAA_5555, 0);
      drive(0, 1, 0, 0, 0, 32'h300, 128'h0, 0);
      chk1("t4 w valid", dram_req_valid, 1'b1);
      chk1("t4 w we", dram_req_we, 1'b1);
      chkw("t4 w addr", 128'(dram_req_addr), 128'h200);
      chkw("t4 w data", dram_req_wdata, 128'hAAAA_5555);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t4 w valid held", dram_req_valid, 1'b1);
      chkw("t4 w data held", dram_req_wdata, 128'hAAAA_5555);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      chk1("t4 w we at accept", dram_req_we, 1'b1);
      chkw("t4 w addr at accept", 128'(dram_req_addr), 128'h200);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t4 r valid", dram_req_valid, 1'b1);
      chk1("t4 r we", dram_req_we, 1'b0);
      chkw("t4 r addr", 128'(dram_req_addr), 128'h300);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      chk1("t4 r valid at accept", dram_req_valid, 1'b1);
      drive(0, 0, 0, 1, 1, 0, 0, 128'h77);
      chk1("t4 empty", dram_req_valid, 1'b0);
      chk1("t4 busy", busy, 1'b1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t4 rvalid", acc_rvalid, 1'b1);
      chkw("t4 rdata", acc_rdata, 128'h77);
      chk1("t4 busy end", busy, 1'b0);

      // Reset with three queued and two outstanding
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 1, 0, 32'h10, 0, 0);
      drive(0, 1, 0, 1, 0, 32'h20, 0, 0);
      drive(0, 1, 0, 1, 0, 32'h30, 0, 0);
      drive(0, 1, 0, 0, 0, 32'h40, 0, 0);
      drive(0, 1, 0, 0, 0, 32'h50, 0, 0);
      chk1("t6 busy before rst", busy, 1'b1);
      drive(1, 0, 0, 0, 1, 0, 0, 128'h99);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t6 valid", dram_req_valid, 1'b0);
      chk1("t6 stall", acc_stall, 1'b0);
      chk1("t6 rvalid", acc_rvalid, 1'b0);
      chkw("t6 rdata", acc_rdata, 128'h0);
      chk1("t6 we", dram_req_we, 1'b0);
      chkw("t6 addr", 128'(dram_req_addr), 128'h0);
      chkw("t6 wdata", dram_req_wdata, 128'h0);
      chk1("t6 busy", busy, 1'b0);
      chk1("t6 ovf", err_overflow, 1'b0);
      chk1("t6 unexp", err_unexp_rsp, 1'b0);
      drive(0, 0, 0, 0, 1, 0, 0, 128'h5);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk1("t6 late rsp unexp", err_unexp_rsp, 1'b1);
      chk1("t6 late rsp rvalid", acc_rvalid, 1'b0);

      // Randomized traffic against a queue-based reference model
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      outst_m = 0; exp_rv = 1'b0; exp_rd = '0; ovf_m = 1'b0;
      mq.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         chk1("rnd rvalid", acc_rvalid, exp_rv);
         if (exp_rv) chkw("rnd rdata", acc_rdata, exp_rd);
         rd = ($urandom_range(0, 99) < 45);
         wr = ($urandom_range(0, 99) < 25);
         rst = 1'b0;
         acc_read = rd;
         acc_write = wr;
         acc_addr = $urandom;
         acc_wdata = {$urandom, $urandom, $urandom, $urandom};
         dram_req_ready = ($urandom_range(0, 99) < ((cyc / 500) % 2 == 0 ? 70 : 30));
         dram_rsp_valid = (outst_m > 0) && ($urandom_range(0, 99) < 35);
         dram_rsp_data = {$urandom, $urandom, $urandom, $urandom};
         #1;
         full_m = (mq.size() == DEPTH);
         exp_valid = (mq.size() > 0) && (mq[0].we || outst_m < MAXO);
         chk1("rnd stall", acc_stall, full_m);
         chk1("rnd valid", dram_req_valid, exp_valid);
         chk1("rnd busy", busy, (mq.size() > 0) || (outst_m > 0));
         if (exp_valid) begin
            chk1("rnd we", dram_req_we, mq[0].we);
            chkw("rnd addr", 128'(dram_req_addr), 128'(mq[0].addr));
            if (mq[0].we) chkw("rnd wdata", dram_req_wdata, mq[0].wdata);
         end
         exp_rv = dram_rsp_valid && (outst_m > 0);
         if (exp_rv) begin
            exp_rd = dram_rsp_data;
            outst_m--;
         end
         if (exp_valid && dram_req_ready) begin
            if (!mq[0].we) outst_m++;
            void'(mq.pop_front());
         end
         if ((rd && wr) || ((rd ^ wr) && full_m)) ovf_m = 1'b1;
         if ((rd ^ wr) && !full_m) mq.push_back('{wr, acc_addr, acc_wdata});
      end
      @(negedge clk);
      chk1("rnd final rvalid", acc_rvalid, exp_rv);
      chk1("rnd ovf", err_overflow, ovf_m);
      chk1("rnd unexp", err_unexp_rsp, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
